// File: rtl/game_session_ctrl_if.sv
// Bundle of game-screen inputs and session status outputs for game_session_ctrl.
interface game_session_ctrl_if;
   logic       menu_or_game;
   logic [1:0] mode;
   logic       start;
   logic       key_valid;
   logic [7:0] key_code;
   logic [7:0] target_code;
   logic [2:0] state;
   logic [6:0] time_left;
   logic [9:0] score;
   logic [7:0] hits;
   logic [7:0] misses;
   logic       req_next;
   logic       game_over;

   // Driver side: menu/keyboard front end
   modport master (
      output menu_or_game, mode, start, key_valid, key_code, target_code,
      input  state, time_left, score, hits, misses, req_next, game_over
   );

   // Controller side
   modport slave (
      input  menu_or_game, mode, start, key_valid, key_code, target_code,
      output state, time_left, score, hits, misses, req_next, game_over
   );
endinterface

// File: rtl/game_session_ctrl.sv
// Typing-game session controller: menu/ready/run/pause/over sequencing,
// one-second countdown, and score/hit/miss bookkeeping for keystrokes.
module game_session_ctrl #(
   parameter int TICK_DIV = 50_000_000,
   parameter int T_EASY   = 60,
   parameter int T_MID    = 45,
   parameter int T_HARD   = 30
) (
   input  logic               clk,
   input  logic               rst_n,
   game_session_ctrl_if.slave bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] READY = 3'd1;
   localparam logic [2:0] RUN   = 3'd2;
   localparam logic [2:0] PAUSE = 3'd3;
   localparam logic [2:0] OVER  = 3'd4;

   logic          menu_meta, menu_sync;
   logic [1:0]    mode_meta, mode_sync;
   logic          start_meta, start_sync;

   logic [2:0]    state_reg, state_next;
   logic [6:0]    time_left_reg, time_left_next;
   logic [9:0]    score_reg, score_next;
   logic [7:0]    hits_reg, hits_next;
   logic [7:0]    misses_reg, misses_next;
   logic          req_next_reg, req_next_next;
   logic [PW-1:0] presc_reg, presc_next;

   logic [6:0]    limit;
   logic [9:0]    weight;
   logic [10:0]   score_sum;
   logic          tick;
   logic          over_now;

   // Two-flop synchronizers for the level inputs coming from outside clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         menu_meta  <= 1'b1;
         menu_sync  <= 1'b1;
         mode_meta  <= 2'd0;
         mode_sync  <= 2'd0;
         start_meta <= 1'b0;
         start_sync <= 1'b0;
      end else begin
         menu_meta  <= bus.menu_or_game;
         menu_sync  <= menu_meta;
         mode_meta  <= bus.mode;
         mode_sync  <= mode_meta;
         start_meta <= bus.start;
         start_sync <= start_meta;
      end
   end

   // Time limit and per-hit score weight for the synchronized mode (3 acts as 0)
   always_comb begin
      case (mode_sync)
         2'd1:    limit = 7'(T_MID);
         2'd2:    limit = 7'(T_HARD);
         default: limit = 7'(T_EASY);
      endcase
      weight = (mode_sync == 2'd3) ? 10'd1 : {8'd0, mode_sync} + 10'd1;
   end

   assign score_sum = {1'b0, score_reg} + {1'b0, weight};
   assign tick      = (presc_reg == PRESC_MAX);
   // Final tick (or an already-expired timer) ends the game; beats a pause request
   assign over_now  = (time_left_reg == 7'd0) || (tick && time_left_reg == 7'd1);

   // Next-state, countdown and scoring decisions
   always_comb begin
      state_next     = state_reg;
      time_left_next = time_left_reg;
      score_next     = score_reg;
      hits_next      = hits_reg;
      misses_next    = misses_reg;
      presc_next     = presc_reg;
      req_next_next  = 1'b0;
      if (menu_sync) begin
         state_next     = IDLE;
         time_left_next = limit;
         score_next     = 10'd0;
         hits_next      = 8'd0;
         misses_next    = 8'd0;
         presc_next     = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               time_left_next = limit;
               score_next     = 10'd0;
               hits_next      = 8'd0;
               misses_next    = 8'd0;
               presc_next     = '0;
               state_next     = READY;
            end
            READY: begin
               presc_next = '0;
               if (start_sync) state_next = RUN;
            end
            RUN: begin
               // A key on the final-tick edge is still scored
               if (bus.key_valid) begin
                  if (bus.key_code == bus.target_code) begin
                     hits_next     = (hits_reg == 8'hFF) ? hits_reg : hits_reg + 8'd1;
                     score_next    = (score_sum > 11'd999) ? 10'd999 : score_sum[9:0];
                     req_next_next = 1'b1;
                  end else begin
                     misses_next = (misses_reg == 8'hFF) ? misses_reg : misses_reg + 8'd1;
                     score_next  = (score_reg == 10'd0) ? 10'd0 : score_reg - 10'd1;
                  end
               end
               if (tick) begin
                  presc_next = '0;
                  if (time_left_reg != 7'd0) time_left_next = time_left_reg - 7'd1;
               end else begin
                  presc_next = presc_reg + 1'b1;
               end
               if (over_now)         state_next = OVER;
               else if (!start_sync) state_next = PAUSE;
            end
            PAUSE: begin
               if (start_sync) state_next = RUN;
            end
            OVER: begin
               if (!start_sync) begin
                  state_next     = READY;
                  time_left_next = limit;
                  score_next     = 10'd0;
                  hits_next      = 8'd0;
                  misses_next    = 8'd0;
                  presc_next     = '0;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Session state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         time_left_reg <= 7'(T_EASY);
         score_reg     <= 10'd0;
         hits_reg      <= 8'd0;
         misses_reg    <= 8'd0;
         req_next_reg  <= 1'b0;
         presc_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         time_left_reg <= time_left_next;
         score_reg     <= score_next;
         hits_reg      <= hits_next;
         misses_reg    <= misses_next;
         req_next_reg  <= req_next_next;
         presc_reg     <= presc_next;
      end
   end

   assign bus.state     = state_reg;
   assign bus.time_left = time_left_reg;
   assign bus.score     = score_reg;
   assign bus.hits      = hits_reg;
   assign bus.misses    = misses_reg;
   assign bus.req_next  = req_next_reg;
   assign bus.game_over = (state_reg == OVER);
endmodule

// File: doc/game_session_ctrl.md
GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clk cycles per one-second game tick.
REQ-002 Parameter T_EASY, default 60, seconds allowed in mode 0.
REQ-003 Parameter T_MID, default 45, seconds allowed in mode 1.
REQ-004 Parameter T_HARD, default 30, seconds allowed in mode 2.
REQ-005 clk  input  1  single system clock; all logic rising-edge clk.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 menu_or_game  input  1  1 = main menu, 0 = game screen; asynchronous to clk.
REQ-008 mode  input  2  difficulty 0/1/2; value 3 is treated as 0; asynchronous to clk.
REQ-009 start  input  1  level, 1 = run, 0 = stop/pause; asynchronous to clk.
REQ-010 key_valid  input  1  one-cycle strobe, key_code valid.
REQ-011 key_code  input  8  ASCII of typed key.
REQ-012 target_code  input  8  ASCII of character currently displayed.
REQ-013 state  output  3  IDLE=0, READY=1, RUN=2, PAUSE=3, OVER=4.
REQ-014 time_left  output  7  seconds remaining, binary.
REQ-015 score  output  10  current score, binary, 0..999.
REQ-016 hits  output  8  correct keys; misses output 8 wrong keys.
REQ-017 req_next  output  1  one-cycle pulse requesting a new target character.
REQ-018 game_over  output  1  high while state==OVER.

Function
REQ-019 menu_or_game, mode and start each pass through a two-flop synchronizer; all decisions use synchronized values (2-cycle input latency).
REQ-020 FSM: synced menu_or_game=1 forces IDLE from any state, highest priority.
REQ-021 IDLE: time_left loaded every cycle with limit for current mode; score/hits/misses cleared; menu_or_game=0 -> READY.
REQ-022 READY: limit, score, hits, misses held at values loaded in IDLE/OVER exit; start=1 -> RUN.
REQ-023 RUN: start=0 -> PAUSE; time_left reaching 0 -> OVER; if both occur in one cycle, OVER wins.
REQ-024 PAUSE: prescaler and time_left frozen, keys ignored; start=1 -> RUN, prescaler resumes from held count.
REQ-025 OVER: counters frozen; start=0 -> READY with time_left reloaded for current mode and score/hits/misses cleared.
REQ-026 Mode changes affect time_left only in IDLE or on OVER->READY reload.
REQ-027 Prescaler counts 0..TICK_DIV-1 only in RUN; at TICK_DIV-1 it wraps to 0 and time_left decrements by 1; prescaler clears on entering READY.
REQ-028 Decrement from 1 to 0 moves state to OVER on the same clock edge; time_left never underflows.
REQ-029 key_valid honoured only when state==RUN; otherwise ignored with no side effects.
REQ-030 Match (key_code==target_code): hits+1, score + (mode+1) (mode 3 weighs 1), req_next pulses next cycle.
REQ-031 Mismatch: misses+1, score-1; no req_next.
REQ-032 score saturates at 999 and at 0; hits/misses saturate at 255.
REQ-033 key_valid on the same edge as the final tick is scored before OVER takes effect.
REQ-034 req_next is exactly one cycle wide per match; no pulse outside RUN-originated matches.

Reset
REQ-035 rst_n=0 asynchronously sets state=IDLE, time_left=T_EASY, score=0, hits=0, misses=0, req_next=0, game_over=0, prescaler=0, synchronizer flops to menu_or_game=1/mode=0/start=0.
REQ-036 Reset asserted mid-game discards all progress; after release block behaves as after power-up.

Verification (TICK_DIV=4)
REQ-037 Reset, menu_or_game=1, mode=2 -> state=0, time_left=30 within 3 cycles.
REQ-038 menu_or_game=0 then start=1 -> state READY then RUN; time_left decrements every 4 cycles; after 30 ticks state=4, game_over=1, time_left=0.
REQ-039 In RUN mode 1, key_valid with key_code=target_code=0x41 -> score+2, hits=1, req_next one cycle; key_code=0x42 -> misses=1, score back to 1.
REQ-040 Mismatch at score=0 -> score stays 0; 1000 mode-2 matches -> score holds 999, hits 255.
REQ-041 start=0 in RUN for 20 cycles -> PAUSE, time_left unchanged, keys ignored; start=1 -> resumes without skipped tick.
REQ-042 menu_or_game=1 during RUN -> IDLE within 3 cycles, counters cleared; rst_n pulse mid-RUN -> all outputs at reset values immediately.
